// File: rtl/sub_bytes_pkg.sv
// Shared types and the forward AES S-box table for the SubBytes round stage.
package sub_bytes_pkg;

    localparam int AES_BYTES = 16;

    typedef logic [7:0]  byte_t;
    typedef byte_t [15:0] state_t;

    // Forward S-box: GF(2^8) inverse (0 -> 0) followed by the affine map with constant 0x63.
    localparam byte_t SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Single-byte forward S-box lookup, purely combinational.
module aes_sbox
    import sub_bytes_pkg::*;
(
    input  logic [7:0] in,
    output logic [7:0] out
);

    // Table lookup; synthesis folds the constant array into logic.
    always_comb begin
        out = SBOX[in];
    end

endmodule

// File: rtl/sub_bytes.sv
// AES SubBytes round stage: 16 parallel S-box lookups feeding a 128-bit output register.
// Optional SUB_BYTES_VALID_EN adds in_valid/out_valid; out then loads only on valid edges.
module sub_bytes
    import sub_bytes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] in,
`ifdef SUB_BYTES_VALID_EN
    input  logic         in_valid,
    output logic         out_valid,
`endif
    output logic [127:0] out
);

    state_t sub_d;

    // Byte k occupies in[127-8k -: 8]; lanes are independent, no reordering.
    for (genvar k = 0; k < AES_BYTES; k++) begin : g_lane
        aes_sbox u_sbox (
            .in  (in[127-8*k -: 8]),
            .out (sub_d[AES_BYTES-1-k])
        );
    end

`ifdef SUB_BYTES_VALID_EN
    // Output register loads only when qualified; the valid flag follows in_valid every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= sub_d;
            end
        end
    end
`else
    // Output register loads every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= sub_d;
        end
    end
`endif

endmodule

// File: tb/tb_sub_bytes.sv
// Directed bench for sub_bytes; reference S-box is computed from GF(2^8) arithmetic.
module tb_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic [127:0] in;
    logic [127:0] out;
`ifdef SUB_BYTES_VALID_EN
    logic         in_valid;
    logic         out_valid;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]   ref_tbl [0:255];
    logic [127:0] exp_v;
    logic [127:0] prev_v;

    sub_bytes dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
`ifdef SUB_BYTES_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .out       (out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int c = 1; c < 256; c++) begin
                if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
            end
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    logic [7:0] sb_in  [4] = '{8'h00, 8'h01, 8'h53, 8'hff};
    logic [7:0] sb_exp [4] = '{8'h63, 8'h7c, 8'hed, 8'h16};

    logic [127:0] st_in  [3] = '{128'ha49c7ff2689f352b6b5bea43026a5049,
                                 128'haa8f5f0361dde3ef82d24ad26832469a,
                                 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    logic [127:0] st_exp [3] = '{128'h49ded28945db96f17f39871a7702533b,
                                 128'hac73cf7befc111df13b5d6b545235ab8,
                                 128'hd42711aee0bf98f1b8b45de51e415230};

    initial begin
        for (int v = 0; v < 256; v++) ref_tbl[v] = ref_sbox(8'(v));

        rst_n = 1'b1;
        in    = {128{1'b1}};
`ifdef SUB_BYTES_VALID_EN
        in_valid = 1'b1;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async", out, 128'h0);
`ifdef SUB_BYTES_VALID_EN
        chk("reset_valid", {127'h0, out_valid}, 128'h0);
`endif
        tick();
        chk("reset_hold1", out, 128'h0);
        tick();
        chk("reset_hold2", out, 128'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("release_load", out, {16{8'h16}});

        for (int i = 0; i < 4; i++) begin
            in = {sb_in[i], 120'h0};
            tick();
            chk($sformatf("byte0_%h", sb_in[i]), out, {sb_exp[i], {15{8'h63}}});
        end

        in = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        tick();
        chk("fips_b1", out, 128'hd42711aee0bf98f1b8b45de51e415230);

        for (int i = 0; i < 3; i++) begin
            in = st_in[i];
            tick();
            chk($sformatf("stream_%0d", i), out, st_exp[i]);
        end

`ifdef SUB_BYTES_VALID_EN
        prev_v   = st_exp[2];
        in       = st_in[0];
        in_valid = 1'b0;
        tick();
        chk("valid_hold_out", out, prev_v);
        chk("valid_hold_flag", {127'h0, out_valid}, 128'h0);
        in_valid = 1'b1;
        tick();
        chk("valid_load_out", out, st_exp[0]);
        chk("valid_load_flag", {127'h0, out_valid}, 128'h1);
`endif

        in = st_in[1];
        #3 rst_n = 1'b0;
        #1;
        chk("reset_midstream", out, 128'h0);
`ifdef SUB_BYTES_VALID_EN
        chk("reset_mid_valid", {127'h0, out_valid}, 128'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        in    = st_in[0];
        tick();
        chk("post_reset_load", out, st_exp[0]);

        for (int v = 0; v < 256; v++) begin
            for (int k = 0; k < 16; k++) begin
                logic [7:0] b;
                b = 8'(v + 17 * k);
                in[127-8*k -: 8]    = b;
                exp_v[127-8*k -: 8] = ref_tbl[b];
            end
            tick();
            chk($sformatf("sweep_%0d", v), out, exp_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
